// File: rtl/inst_mem_server_if.sv
// Fetch and loader signal bundle for inst_mem_server.
// checksum_o exists only when IMEM_CHECKSUM_EN is defined.
interface inst_mem_server_if;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        core_rst_o;
  logic        boot_i;
  logic        load_valid_i;
  logic [31:0] load_data_i;
  logic        load_last_i;
  logic        load_ready_o;
  logic        load_done_o;
  logic        load_err_o;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif

  modport slave (
    input  inst_addr_i, boot_i, load_valid_i, load_data_i, load_last_i,
    output inst_o, core_rst_o, load_ready_o, load_done_o, load_err_o
`ifdef IMEM_CHECKSUM_EN
    , output checksum_o
`endif
  );

  modport master (
    output inst_addr_i, boot_i, load_valid_i, load_data_i, load_last_i,
    input  inst_o, core_rst_o, load_ready_o, load_done_o, load_err_o
`ifdef IMEM_CHECKSUM_EN
    , input checksum_o
`endif
  );
endinterface

// File: rtl/inst_mem_server.sv
// Instruction memory for the M10 fetch port with a streaming image loader that gates core reset.
// Optional XOR checksum of loaded words enabled by defining IMEM_CHECKSUM_EN.
module inst_mem_server #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] FILL_INST = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  inst_mem_server_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;

  typedef enum logic [1:0] {WAIT, LOAD, RUN, ERR} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic             done;
  logic             ready;
  logic             xfer;
  logic             at_end;
  logic [31:0]      word_addr;
  logic             in_range;
  logic [31:0]      mem [DEPTH];

  always_comb begin
    state_nxt = state;
    ready     = (state == WAIT) || (state == LOAD);
    xfer      = bus.load_valid_i & ready;
    at_end    = (wr_ptr == PTR_W'(DEPTH - 1));
    unique case (state)
      WAIT: begin
        // A transfer takes priority over a boot request in the same cycle.
        if (xfer) begin
          if (bus.load_last_i) state_nxt = RUN;
          else if (at_end)     state_nxt = ERR;
          else                 state_nxt = LOAD;
        end else if (bus.boot_i) begin
          state_nxt = RUN;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (bus.load_last_i) state_nxt = RUN;
          else if (at_end)     state_nxt = ERR;
        end
      end
      RUN:     state_nxt = RUN;
      ERR:     state_nxt = ERR;
      default: state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= WAIT;
      wr_ptr <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (bus.load_last_i) done <= 1'b1;
      end
    end
  end

  // Array is intentionally not reset so an image preloaded by the simulator or a prior load survives.
  always_ff @(posedge clk_i) begin
    if (xfer) mem[wr_ptr[ADDR_W-1:0]] <= bus.load_data_i;
  end

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] checksum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     checksum <= '0;
    else if (xfer) checksum <= checksum ^ bus.load_data_i;
  end

  assign bus.checksum_o = checksum;
`endif

  // Byte-offset bits drop out in the shift; anything above the array is out of range.
  assign word_addr = bus.inst_addr_i >> 2;
  assign in_range  = ((word_addr >> ADDR_W) == 32'd0);

  assign bus.inst_o       = ((state == RUN) && in_range) ? mem[word_addr[ADDR_W-1:0]] : FILL_INST;
  assign bus.core_rst_o   = (state != RUN);
  assign bus.load_ready_o = ready;
  assign bus.load_done_o  = done;
  assign bus.load_err_o   = (state == ERR);
endmodule

// File: tb/tb_inst_mem_server.sv
// Directed self-checking bench for inst_mem_server (ADDR_W=10 main instance, ADDR_W=2 overflow instance).
module tb_inst_mem_server;
  localparam logic [31:0] FILL = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  inst_mem_server_if bus ();
  inst_mem_server_if sbus ();

  inst_mem_server #(.ADDR_W(10), .FILL_INST(FILL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  inst_mem_server #(.ADDR_W(2), .FILL_INST(32'h0)) dut_small (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (sbus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_addr_i   = 32'h0;
    bus.boot_i        = 1'b0;
    bus.load_valid_i  = 1'b0;
    bus.load_data_i   = 32'h0;
    bus.load_last_i   = 1'b0;
    sbus.inst_addr_i  = 32'h0;
    sbus.boot_i       = 1'b0;
    sbus.load_valid_i = 1'b0;
    sbus.load_data_i  = 32'h0;
    sbus.load_last_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.core_rst_o !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst got=%b exp=1", bus.core_rst_o); end
    n_cmp++; if (bus.load_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.load_ready_o); end
    n_cmp++; if (bus.load_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.load_done_o); end
    n_cmp++; if (bus.load_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.load_err_o); end
    n_cmp++; if (bus.inst_o !== FILL) begin n_fail++; $display("FAIL reset_inst got=%h exp=%h", bus.inst_o, FILL); end
    n_cmp++; if (dut.wr_ptr !== 11'd0) begin n_fail++; $display("FAIL reset_wr_ptr got=%0d exp=0", dut.wr_ptr); end
`ifdef IMEM_CHECKSUM_EN
    n_cmp++; if (bus.checksum_o !== 32'h0) begin n_fail++; $display("FAIL reset_checksum got=%h exp=0", bus.checksum_o); end
`endif
  endtask

  task automatic test_stream();
    do_reset();
    bus.load_valid_i = 1'b1;
    bus.load_data_i  = 32'h0050_0093;
    step();
    bus.load_data_i  = 32'h00A0_0113;
    step();
    n_cmp++; if (dut.wr_ptr !== 11'd2) begin n_fail++; $display("FAIL stream_wr_ptr got=%0d exp=2", dut.wr_ptr); end
    n_cmp++; if (bus.load_ready_o !== 1'b1) begin n_fail++; $display("FAIL stream_ready got=%b exp=1", bus.load_ready_o); end
    n_cmp++; if (bus.core_rst_o !== 1'b1) begin n_fail++; $display("FAIL stream_core_rst_loading got=%b exp=1", bus.core_rst_o); end
    bus.load_data_i  = 32'h0020_81B3;
    bus.load_last_i  = 1'b1;
    step();
    bus.load_valid_i = 1'b0;
    bus.load_last_i  = 1'b0;
    n_cmp++; if (bus.core_rst_o !== 1'b0) begin n_fail++; $display("FAIL stream_core_rst_run got=%b exp=0", bus.core_rst_o); end
    n_cmp++; if (bus.load_done_o !== 1'b1) begin n_fail++; $display("FAIL stream_done got=%b exp=1", bus.load_done_o); end
    n_cmp++; if (bus.load_ready_o !== 1'b0) begin n_fail++; $display("FAIL stream_ready_run got=%b exp=0", bus.load_ready_o); end
    bus.inst_addr_i = 32'h8; #1;
    n_cmp++; if (bus.inst_o !== 32'h0020_81B3) begin n_fail++; $display("FAIL stream_read8 got=%h exp=002081b3", bus.inst_o); end
    bus.inst_addr_i = 32'h0; #1;
    n_cmp++; if (bus.inst_o !== 32'h0050_0093) begin n_fail++; $display("FAIL stream_read0 got=%h exp=00500093", bus.inst_o); end
    bus.inst_addr_i = 32'h7; #1;
    n_cmp++; if (bus.inst_o !== 32'h00A0_0113) begin n_fail++; $display("FAIL stream_read_unaligned got=%h exp=00a00113", bus.inst_o); end
  endtask

  task automatic test_throttle();
    logic        v [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] w [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    int k = 0;
    int exp_ptr = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.load_valid_i = v[i];
      bus.load_data_i  = v[i] ? w[k] : 32'hBAD0_BAD0;
      bus.load_last_i  = v[i] && (k == 3);
      n_cmp++; if (bus.load_ready_o !== 1'b1) begin n_fail++; $display("FAIL throttle_ready cyc=%0d got=%b exp=1", i, bus.load_ready_o); end
      step();
      if (v[i]) begin k++; exp_ptr++; end
      n_cmp++; if (dut.wr_ptr !== 11'(exp_ptr)) begin n_fail++; $display("FAIL throttle_wr_ptr cyc=%0d got=%0d exp=%0d", i, dut.wr_ptr, exp_ptr); end
    end
    bus.load_valid_i = 1'b0;
    bus.load_last_i  = 1'b0;
    n_cmp++; if (bus.core_rst_o !== 1'b0) begin n_fail++; $display("FAIL throttle_core_rst got=%b exp=0", bus.core_rst_o); end
    bus.inst_addr_i = 32'hC; #1;
    n_cmp++; if (bus.inst_o !== 32'h4444_0004) begin n_fail++; $display("FAIL throttle_mem3 got=%h exp=44440004", bus.inst_o); end
    bus.inst_addr_i = 32'h4; #1;
    n_cmp++; if (bus.inst_o !== 32'h2222_0002) begin n_fail++; $display("FAIL throttle_mem1 got=%h exp=22220002", bus.inst_o); end
  endtask

  task automatic test_overflow();
    logic [31:0] w [5] = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 32'hC000_0004};
    do_reset();
    sbus.load_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sbus.load_data_i = w[i];
      step();
      if (i < 3) begin
        n_cmp++; if (sbus.load_err_o !== 1'b0) begin n_fail++; $display("FAIL ovf_err_early word=%0d got=%b exp=0", i, sbus.load_err_o); end
      end
    end
    sbus.load_valid_i = 1'b0;
    n_cmp++; if (sbus.load_err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_err got=%b exp=1", sbus.load_err_o); end
    n_cmp++; if (sbus.load_ready_o !== 1'b0) begin n_fail++; $display("FAIL ovf_ready got=%b exp=0", sbus.load_ready_o); end
    n_cmp++; if (sbus.core_rst_o !== 1'b1) begin n_fail++; $display("FAIL ovf_core_rst got=%b exp=1", sbus.core_rst_o); end
    n_cmp++; if (dut_small.wr_ptr !== 3'd4) begin n_fail++; $display("FAIL ovf_wr_ptr got=%0d exp=4", dut_small.wr_ptr); end
    n_cmp++; if (dut_small.mem[3] !== 32'hC000_0003) begin n_fail++; $display("FAIL ovf_mem3 got=%h exp=c0000003", dut_small.mem[3]); end
    n_cmp++; if (dut_small.mem[0] !== 32'hC000_0000) begin n_fail++; $display("FAIL ovf_mem0 got=%h exp=c0000000", dut_small.mem[0]); end
  endtask

  task automatic test_midload_reset();
    logic [31:0] b [3] = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002};
    do_reset();
    bus.load_valid_i = 1'b1;
    bus.load_data_i  = 32'hA000_0000;
    step();
    bus.load_data_i  = 32'hA000_0001;
    step();
    bus.load_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (dut.wr_ptr !== 11'd0) begin n_fail++; $display("FAIL midrst_wr_ptr got=%0d exp=0", dut.wr_ptr); end
    n_cmp++; if (bus.core_rst_o !== 1'b1) begin n_fail++; $display("FAIL midrst_core_rst got=%b exp=1", bus.core_rst_o); end
    n_cmp++; if (bus.load_ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", bus.load_ready_o); end
    step();
    rst = 1'b0;
    bus.load_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.load_data_i = b[i];
      bus.load_last_i = (i == 2);
      step();
    end
    bus.load_valid_i = 1'b0;
    bus.load_last_i  = 1'b0;
    n_cmp++; if (bus.core_rst_o !== 1'b0) begin n_fail++; $display("FAIL midrst_run got=%b exp=0", bus.core_rst_o); end
    for (int i = 0; i < 3; i++) begin
      bus.inst_addr_i = 32'(i * 4); #1;
      n_cmp++; if (bus.inst_o !== b[i]) begin n_fail++; $display("FAIL midrst_read word=%0d got=%h exp=%h", i, bus.inst_o, b[i]); end
    end
  endtask

  task automatic test_boot();
    do_reset();
    bus.inst_addr_i = 32'h4; #1;
    n_cmp++; if (bus.inst_o !== FILL) begin n_fail++; $display("FAIL boot_wait_fill got=%h exp=%h", bus.inst_o, FILL); end
    bus.boot_i = 1'b1;
    step();
    bus.boot_i = 1'b0;
    n_cmp++; if (bus.core_rst_o !== 1'b0) begin n_fail++; $display("FAIL boot_core_rst got=%b exp=0", bus.core_rst_o); end
    n_cmp++; if (bus.load_done_o !== 1'b0) begin n_fail++; $display("FAIL boot_done got=%b exp=0", bus.load_done_o); end
    n_cmp++; if (bus.inst_o !== 32'hB000_0001) begin n_fail++; $display("FAIL boot_retained got=%h exp=b0000001", bus.inst_o); end
    bus.inst_addr_i = 32'h1000; #1;
    n_cmp++; if (bus.inst_o !== FILL) begin n_fail++; $display("FAIL boot_oor got=%h exp=%h", bus.inst_o, FILL); end
    bus.load_valid_i = 1'b1;
    bus.load_data_i  = 32'hCAFE_BABE;
    step();
    bus.load_valid_i = 1'b0;
    bus.inst_addr_i  = 32'h0; #1;
    n_cmp++; if (bus.inst_o !== 32'hB000_0000) begin n_fail++; $display("FAIL boot_no_write got=%h exp=b0000000", bus.inst_o); end
    n_cmp++; if (dut.wr_ptr !== 11'd0) begin n_fail++; $display("FAIL boot_wr_ptr got=%0d exp=0", dut.wr_ptr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.boot_i       = 1'b1;
    bus.load_valid_i = 1'b1;
    bus.load_data_i  = 32'hFFFF_0000;
    step();
    bus.load_valid_i = 1'b0;
    n_cmp++; if (bus.core_rst_o !== 1'b1) begin n_fail++; $display("FAIL b2b_boot_ignored got=%b exp=1", bus.core_rst_o); end
    n_cmp++; if (dut.wr_ptr !== 11'd1) begin n_fail++; $display("FAIL b2b_wr_ptr got=%0d exp=1", dut.wr_ptr); end
    step();
    bus.boot_i = 1'b0;
    n_cmp++; if (bus.core_rst_o !== 1'b1) begin n_fail++; $display("FAIL b2b_boot_in_load got=%b exp=1", bus.core_rst_o); end
    bus.load_valid_i = 1'b1;
    bus.load_data_i  = 32'h0000_FFFF;
    bus.load_last_i  = 1'b1;
    step();
    bus.load_last_i  = 1'b0;
    bus.load_data_i  = 32'h1234_5678;
    n_cmp++; if (bus.load_done_o !== 1'b1) begin n_fail++; $display("FAIL b2b_done got=%b exp=1", bus.load_done_o); end
`ifdef IMEM_CHECKSUM_EN
    n_cmp++; if (bus.checksum_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL csum_value got=%h exp=ffffffff", bus.checksum_o); end
    step();
    n_cmp++; if (bus.checksum_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL csum_hold_run got=%h exp=ffffffff", bus.checksum_o); end
`endif
    bus.load_valid_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stream();
    test_throttle();
    test_overflow();
    test_midload_reset();
    test_boot();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
